// File: rtl/sparc_pkg.sv
// Shared SPARC integer-unit definitions: Bicc condition encodings, icc bit layout and the
// branch-condition evaluator used by the condition-code/writeback stage.
package sparc_pkg;

  typedef enum logic [3:0] {
    COND_BN   = 4'b0000,
    COND_BE   = 4'b0001,
    COND_BLE  = 4'b0010,
    COND_BL   = 4'b0011,
    COND_BLEU = 4'b0100,
    COND_BCS  = 4'b0101,
    COND_BNEG = 4'b0110,
    COND_BVS  = 4'b0111,
    COND_BA   = 4'b1000,
    COND_BNE  = 4'b1001,
    COND_BG   = 4'b1010,
    COND_BGE  = 4'b1011,
    COND_BGU  = 4'b1100,
    COND_BCC  = 4'b1101,
    COND_BPOS = 4'b1110,
    COND_BVC  = 4'b1111
  } bicc_cond_e;

  localparam int unsigned ICC_N      = 3;
  localparam int unsigned ICC_Z      = 2;
  localparam int unsigned ICC_V      = 1;
  localparam int unsigned ICC_C      = 0;
  localparam int unsigned OP3_CC_BIT = 4;

  // cond[3] inverts the base test selected by cond[2:0].
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic w_n, w_z, w_v, w_c, w_base;
    w_n = flags[ICC_N];
    w_z = flags[ICC_Z];
    w_v = flags[ICC_V];
    w_c = flags[ICC_C];
    case (cond[2:0])
      3'd0:    w_base = 1'b0;
      3'd1:    w_base = w_z;
      3'd2:    w_base = w_z | (w_n ^ w_v);
      3'd3:    w_base = w_n ^ w_v;
      3'd4:    w_base = w_c | w_z;
      3'd5:    w_base = w_c;
      3'd6:    w_base = w_n;
      default: w_base = w_v;
    endcase
    return w_base ^ cond[3];
  endfunction

endpackage

// File: rtl/alu_cc_writeback_wb_fifo.sv
// DEPTH-entry synchronous FIFO with full/empty flags; head entry is shown combinationally.
module wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_dout    = r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cc_writeback.sv
// ALU downstream stage: holds SPARC icc, resolves Bicc branches with same-cycle flag
// forwarding, and queues register-file writebacks.
module alu_cc_writeback
  import sparc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] result,
  input  logic              n_in,
  input  logic              z_in,
  input  logic              c_in,
  input  logic              v_in,
  input  logic [5:0]        opcode,
  input  logic              wr_en,
  input  logic [4:0]        rd,
  input  logic              icc_load,
  input  logic [3:0]        icc_din,
  input  logic              br_valid,
  input  logic [3:0]        br_cond,
  output logic [3:0]        icc,
  output logic              carry_out,
  output logic              br_taken,
  output logic              br_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd
);

  logic [3:0]          r_icc;
  logic                r_br_taken, r_br_done;
  logic                w_acc, w_cc_upd, w_push, w_pop, w_full, w_empty;
  logic [3:0]          w_icc_next;
  logic [DATA_W+4:0]   w_dout;
  logic                w_unused;

  assign w_unused = ^{opcode[5], opcode[3:0]};

  assign in_ready = ~w_full;
  assign w_acc    = in_valid & in_ready;
  assign w_cc_upd = w_acc & opcode[OP3_CC_BIT];

  // Value icc takes at this edge; branches see it directly.
  always_comb begin
    w_icc_next = r_icc;
    if (icc_load) begin
      w_icc_next = icc_din;
    end else if (w_cc_upd) begin
      w_icc_next = {n_in, z_in, v_in, c_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_icc      <= '0;
      r_br_taken <= 1'b0;
      r_br_done  <= 1'b0;
    end else begin
      r_icc     <= w_icc_next;
      r_br_done <= br_valid;
      if (br_valid) begin
        r_br_taken <= cond_eval(br_cond, w_icc_next);
      end
    end
  end

  assign icc       = r_icc;
  assign carry_out = r_icc[ICC_C];
  assign br_taken  = r_br_taken;
  assign br_done   = r_br_done;

  assign w_push = w_acc & wr_en & (rd != 5'd0);
  assign w_pop  = ~w_empty & wb_ready;

  wb_fifo #(
    .WIDTH (DATA_W + 5),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_din   ({rd, result}),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign wb_valid = ~w_empty;
  assign wb_data  = w_dout[DATA_W-1:0];
  assign wb_rd    = w_dout[DATA_W+4:DATA_W];

endmodule

// File: tb/tb_alu_cc_writeback.sv
// Directed test-plan steps followed by randomized traffic checked against a queue-based model.
module tb_alu_cc_writeback;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset, in_valid, in_ready;
  logic [DATA_W-1:0] result;
  logic              n_in, z_in, c_in, v_in;
  logic [5:0]        opcode;
  logic              wr_en;
  logic [4:0]        rd;
  logic              icc_load;
  logic [3:0]        icc_din;
  logic              br_valid;
  logic [3:0]        br_cond;
  logic [3:0]        icc;
  logic              carry_out, br_taken, br_done, wb_valid, wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [4:0]        wb_rd;

  always #5 clk = ~clk;

  alu_cc_writeback #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .n_in      (n_in),
    .z_in      (z_in),
    .c_in      (c_in),
    .v_in      (v_in),
    .opcode    (opcode),
    .wr_en     (wr_en),
    .rd        (rd),
    .icc_load  (icc_load),
    .icc_din   (icc_din),
    .br_valid  (br_valid),
    .br_cond   (br_cond),
    .icc       (icc),
    .carry_out (carry_out),
    .br_taken  (br_taken),
    .br_done   (br_done),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [3:0]  m_icc;
  logic        m_bt, m_bd;
  logic [36:0] m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bicc truth table by mnemonic, flags given as {N,Z,V,C}.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    n = f[3]; z = f[2]; v = f[1]; cy = f[0];
    case (c)
      4'd0:  return 1'b0;
      4'd8:  return 1'b1;
      4'd1:  return z;
      4'd9:  return !z;
      4'd2:  return z || (n != v);
      4'd10: return !z && (n == v);
      4'd3:  return n != v;
      4'd11: return n == v;
      4'd4:  return cy || z;
      4'd12: return !cy && !z;
      4'd5:  return cy;
      4'd13: return !cy;
      4'd6:  return n;
      4'd14: return !n;
      4'd7:  return v;
      default: return !v;
    endcase
  endfunction

  task automatic check_all();
    logic [36:0] head;
    chk("icc", 64'(icc), 64'(m_icc));
    chk("carry_out", 64'(carry_out), 64'(m_icc[0]));
    chk("in_ready", 64'(in_ready), 64'(m_q.size() < DEPTH));
    chk("br_done", 64'(br_done), 64'(m_bd));
    chk("br_taken", 64'(br_taken), 64'(m_bt));
    chk("wb_valid", 64'(wb_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      head = m_q[0];
      chk("wb_data", 64'(wb_data), 64'(head[31:0]));
      chk("wb_rd", 64'(wb_rd), 64'(head[36:32]));
    end
  endtask

  // Advance one clock: update the model from the inputs present before the edge, then compare.
  task automatic step();
    logic        acc, pop;
    logic [3:0]  f;
    logic [36:0] gone;
    int          sz;
    sz = m_q.size();
    if (reset) begin
      m_icc = 4'b0;
      m_bt  = 1'b0;
      m_bd  = 1'b0;
      m_q.delete();
    end else begin
      acc = in_valid && (sz < DEPTH);
      pop = (sz > 0) && wb_ready;
      if (icc_load) f = icc_din;
      else if (acc && opcode[4]) f = {n_in, z_in, v_in, c_in};
      else f = m_icc;
      m_bd = br_valid;
      if (br_valid) m_bt = ref_cond(br_cond, f);
      m_icc = f;
      if (pop) gone = m_q.pop_front();
      if (acc && wr_en && rd != 5'd0) m_q.push_back({rd, result});
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 1'b0; in_valid = 1'b0; result = '0; opcode = '0;
    {n_in, z_in, v_in, c_in} = 4'b0; wr_en = 1'b0; rd = '0;
    icc_load = 1'b0; icc_din = '0; br_valid = 1'b0; br_cond = '0; wb_ready = 1'b1;
  endtask

  task automatic alu(input logic [5:0] op, input logic [31:0] res, input logic [3:0] nzvc,
                     input logic we, input logic [4:0] r);
    in_valid = 1'b1; opcode = op; result = res;
    {n_in, z_in, v_in, c_in} = nzvc; wr_en = we; rd = r;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    chk("rst_icc", 64'(icc), 64'h0);
    chk("rst_carry", 64'(carry_out), 64'h0);
    chk("rst_br_taken", 64'(br_taken), 64'h0);
    chk("rst_br_done", 64'(br_done), 64'h0);
    chk("rst_wb_valid", 64'(wb_valid), 64'h0);
    chk("rst_wb_data", 64'(wb_data), 64'h0);
    chk("rst_wb_rd", 64'(wb_rd), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // ADDcc with Z and C set, writing %r5
    idle(); alu(6'b010000, 32'h0, 4'b0101, 1'b1, 5'd5);
    step();
    chk("addcc_icc", 64'(icc), 64'h5);
    chk("addcc_carry", 64'(carry_out), 64'h1);
    chk("addcc_wb_valid", 64'(wb_valid), 64'h1);
    chk("addcc_wb_data", 64'(wb_data), 64'h0);
    chk("addcc_wb_rd", 64'(wb_rd), 64'h5);
    idle(); step();

    // Forwarded flags: BL then BGE with N=1, V=0
    alu(6'b010000, 32'h8000_0000, 4'b1000, 1'b0, 5'd0);
    br_valid = 1'b1; br_cond = 4'b0011;
    step();
    chk("fwd_bl_done", 64'(br_done), 64'h1);
    chk("fwd_bl_taken", 64'(br_taken), 64'h1);
    br_cond = 4'b1011;
    step();
    chk("fwd_bge_done", 64'(br_done), 64'h1);
    chk("fwd_bge_taken", 64'(br_taken), 64'h0);
    idle(); step();
    chk("br_done_idle", 64'(br_done), 64'h0);

    // Non-cc ADD leaves icc alone
    icc_load = 1'b1; icc_din = 4'b0000; step();
    idle(); alu(6'b000000, 32'h0, 4'b0100, 1'b0, 5'd0); step();
    chk("add_nocc_icc", 64'(icc), 64'h0);
    idle(); br_valid = 1'b1; br_cond = 4'b0001; step();
    chk("be_taken", 64'(br_taken), 64'h0);

    // Backpressure: fill the queue, hold a third write, then drain in order
    idle(); wb_ready = 1'b0;
    alu(6'b000000, 32'h1111_1111, 4'b0, 1'b1, 5'd1); step();
    chk("bp_ready1", 64'(in_ready), 64'h1);
    chk("bp_data1", 64'(wb_data), 64'h1111_1111);
    alu(6'b000000, 32'h2222_2222, 4'b0, 1'b1, 5'd2); step();
    chk("bp_full", 64'(in_ready), 64'h0);
    alu(6'b000000, 32'h3333_3333, 4'b0, 1'b1, 5'd3); step();
    chk("bp_held_ready", 64'(in_ready), 64'h0);
    chk("bp_head1", 64'(wb_rd), 64'h1);
    wb_ready = 1'b1; step();
    chk("bp_head2", 64'(wb_rd), 64'h2);
    step();
    chk("bp_head3", 64'(wb_rd), 64'h3);
    chk("bp_data3", 64'(wb_data), 64'h3333_3333);
    idle(); step();
    chk("bp_drained", 64'(wb_valid), 64'h0);

    // SUBcc to %g0: flags update, no writeback
    alu(6'b010100, 32'hFFFF_FFFF, 4'b1000, 1'b1, 5'd0); step();
    chk("g0_wb_valid", 64'(wb_valid), 64'h0);
    chk("g0_icc_n", 64'(icc[3]), 64'h1);

    // icc_load beats a simultaneous cc op
    idle(); alu(6'b010000, 32'h0, 4'b0000, 1'b0, 5'd0);
    icc_load = 1'b1; icc_din = 4'b1111; step();
    chk("load_icc", 64'(icc), 64'hF);

    // Reset with two queued entries and a pending branch
    idle(); wb_ready = 1'b0;
    alu(6'b000000, 32'hA, 4'b0, 1'b1, 5'd7); step();
    alu(6'b000000, 32'hB, 4'b0, 1'b1, 5'd8); step();
    chk("pre_rst_wb_valid", 64'(wb_valid), 64'h1);
    idle(); wb_ready = 1'b0; reset = 1'b1; br_valid = 1'b1; br_cond = 4'b1000; step();
    chk("mid_rst_wb_valid", 64'(wb_valid), 64'h0);
    chk("mid_rst_icc", 64'(icc), 64'h0);
    chk("mid_rst_br_done", 64'(br_done), 64'h0);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      in_valid = ($urandom_range(0, 9) < 7);
      opcode   = 6'($urandom);
      result   = $urandom;
      {n_in, z_in, v_in, c_in} = 4'($urandom);
      wr_en    = ($urandom_range(0, 3) != 0);
      rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      icc_load = ($urandom_range(0, 9) == 0);
      icc_din  = 4'($urandom);
      br_valid = $urandom_range(0, 1) == 1;
      br_cond  = 4'($urandom);
      wb_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_cc_writeback.md
Name: alu_cc_writeback

Overview:
- Stage directly downstream of ALU_32bit; consumes its result and N/Z/C/V flags.
- Holds the SPARC integer condition codes (icc) and feeds icc.C back to the ALU carry input for ADDX/SUBX.
- Resolves Bicc branch conditions and buffers register-file writebacks in a 2-entry valid/ready queue toward the register file.

Parameters:
- DATA_W, 32, ALU result / writeback data width
- DEPTH, 2, writeback queue entries (power of two, at least 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ALU output valid this cycle
- in_ready  out  1  stage can accept an ALU output
- result  in  DATA_W  ALU result
- n_in, z_in, c_in, v_in  in  1 each  ALU flags
- opcode  in  6  SPARC op3 of the accepted instruction; bit 4 set means cc-setting variant
- wr_en  in  1  instruction writes rd
- rd  in  5  destination register
- icc_load  in  1  WRPSR-style direct icc write
- icc_din  in  4  {N,Z,V,C} for icc_load
- br_valid  in  1  Bicc evaluation request
- br_cond  in  4  Bicc cond field
- icc  out  4  current {N,Z,V,C}
- carry_out  out  1  icc.C to ALU carry input
- br_taken  out  1  registered branch decision
- br_done  out  1  one-cycle pulse: br_taken valid
- wb_valid  out  1  writeback head valid
- wb_ready  in  1  register file accepts
- wb_data  out  DATA_W  writeback data
- wb_rd  out  5  writeback register

Behaviour:
- Reset: icc=0000, carry_out=0, br_taken=0, br_done=0, wb_valid=0, wb_data=0, wb_rd=0, queue empty, in_ready=1. Reset mid-operation discards queued entries and any pending branch.
- Accept: acc = in_valid & in_ready.
- in_ready = !full. When full, an entry popped in the same cycle does not free space for that cycle.
- icc update at the clock edge, with this priority:
  - icc_load=1: icc <= icc_din. Any simultaneous ALU cc update is dropped.
  - else acc & opcode[4]: icc <= {n_in, z_in, v_in, c_in}.
  - else hold.
- carry_out = icc[0], taken combinationally from the register. Zero latency after the update edge.
- Branch evaluation:
  - br_valid samples effective flags F. F is the value icc will take at this edge (forwarded), so a cc op accepted in the same cycle is seen.
  - br_taken and br_done are registered one cycle later. br_done=0 in all cycles without a request.
- Bicc conditions, with a Bicc bit 3 set giving the inverse of its bit 3 clear pair:
  - 0000 BN → 0; 1000 BA → 1
  - 0001 BE → Z; 1001 BNE → !Z
  - 0010 BLE → Z|(N^V); 1010 BG
  - 0011 BL → N^V; 1011 BGE
  - 0100 BLEU → C|Z; 1100 BGU
  - 0101 BCS → C; 1101 BCC
  - 0110 BNEG → N; 1110 BPOS
  - 0111 BVS → V; 1111 BVC
- Writeback queue:
  - Enqueue on acc & wr_en & (rd != 0). Writes to %g0 and non-writing ops are not enqueued but still update icc.
  - In-order FIFO; pop on wb_valid & wb_ready.
  - wb_data and wb_rd show the head entry; they hold their value when not popped.
  - Push and pop in the same cycle when not full or empty leave the count unchanged.
  - Push into an empty queue is visible as wb_valid the next cycle (1-cycle latency).
  - Pointers wrap modulo DEPTH.
- icc changes only on accepted cc ops or icc_load, never when in_valid & !in_ready.

Decomposition:
- Shared package sparc_pkg:
  - Bicc cond encodings (COND_BN..COND_BVC)
  - icc bit indices (ICC_N=3, ICC_Z=2, ICC_V=1, ICC_C=0)
  - OP3_CC_BIT=4
- Combinational function cond_eval(cond, flags) in the package.
- One sub-module, wb_fifo (DEPTH-entry sync FIFO with full/empty), instantiated for the writeback queue.

Test Plan:
- Reset then ADDcc: opcode=010000, result=0, z_in=1, c_in=1, wr_en=1, rd=5 → next cycle icc=0101, carry_out=1, wb_valid=1, wb_data=0, wb_rd=5.
- Forwarding: ADDcc with n_in=1, v_in=0 and, in the same cycle, br_valid=1, br_cond=0011 (BL) → br_done=1, br_taken=1 next cycle. Repeat with br_cond=1011 (BGE) → br_taken=0.
- Non-cc ADD (opcode=000000) with z_in=1 after icc=0000 → icc stays 0000. Bicc 0001 → taken=0.
- Backpressure: wb_ready=0, push three writes (rd=1,2,3, data 0x11111111, 0x22222222, 0x33333333) → in_ready=0 after two, third held. Raise wb_ready → wb_rd sequence 1, 2, 3 in order.
- %g0 write: wr_en=1, rd=0, subcc setting N → no wb_valid, icc.N=1.
- icc_load=1, icc_din=1111 with simultaneous ADDcc flags 0000 → icc=1111. Assert reset with 2 entries queued → wb_valid=0, icc=0000 next cycle.
